// File: rtl/selector_pipe.sv
// selector_pipe: two-stage pipelined address -> one-hot selector.
//
// Stage 1 predecodes the address into a high-group one-hot and a low-group
// one-hot and classifies the beat (killed / error).  Stage 2 ANDs the two
// one-hots into the full OUT_N-bit select vector.  A valid/ready handshake
// with a combinational ready chain allows full throughput and backpressure.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   address beat present           in_ready   beat accepted this cycle
//   addr       address to decode              en         1 = select, 0 = pass all-zero
//   out_valid  decoded beat present           out_ready  downstream consumes beat
//   decoded    one-hot select (bit addr)      out_err    en=1 and addr > LIMIT
module selector_pipe #(
    parameter int ADDR_W = 16,
    parameter int LO_W   = 8,
    parameter int LIMIT  = 2**ADDR_W - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**ADDR_W-1:0] decoded,
    output logic                 out_err
);
    localparam int OUT_N = 2**ADDR_W;
    localparam int HI_W  = ADDR_W - LO_W;
    localparam int HI_N  = 2**HI_W;
    localparam int LO_N  = 2**LO_W;
    // One extra bit keeps the compare meaningful when LIMIT is the max address.
    localparam logic [ADDR_W:0] LIM_X = (ADDR_W+1)'(LIMIT);

    // Valid bits per stage: [1] = S1, [2] = S2.
    logic [2:1]       r_vld;
    logic [HI_N-1:0]  r_hi;
    logic [LO_N-1:0]  r_lo;
    logic             r_kill1;
    logic             r_err1;
    logic [OUT_N-1:0] r_dec;
    logic             r_err2;

    logic             w_r1;
    logic             w_r2;
    logic             w_over;
    logic [HI_N-1:0]  w_hi;
    logic [LO_N-1:0]  w_lo;
    logic [OUT_N-1:0] w_dec;

    // Ready chain: a stage can load when empty or when the stage after it frees up.
    assign w_r2     = !r_vld[2] || out_ready;
    assign w_r1     = !r_vld[1] || w_r2;
    assign in_ready = w_r1 && !rst;

    assign w_over = {1'b0, addr} > LIM_X;
    assign w_hi   = HI_N'(1) << addr[ADDR_W-1:LO_W];
    assign w_lo   = LO_N'(1) << addr[LO_W-1:0];

    // Each high-group bit gates one LO_N-wide slice of the output with the low one-hot.
    genvar g;
    generate
        for (g = 0; g < HI_N; g++) begin : g_comb
            assign w_dec[g*LO_N +: LO_N] = r_lo & {LO_N{r_hi[g] & !r_kill1}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_r1) r_vld[1] <= in_valid;
            if (w_r2) r_vld[2] <= r_vld[1];
        end
    end

    // Data registers carry no reset: they only matter while their valid is set.
    always_ff @(posedge clk) begin
        if (w_r1 && in_valid) begin
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_kill1 <= !en || w_over;
            r_err1  <= en && w_over;
        end
        if (w_r2 && r_vld[1]) begin
            r_dec  <= w_dec;
            r_err2 <= r_err1;
        end
    end

    assign out_valid = r_vld[2];
    assign decoded   = r_dec & {OUT_N{r_vld[2]}};
    assign out_err   = r_err2 && r_vld[2];

endmodule

// File: tb/tb_selector_pipe.sv
module tb_selector_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default-parameter instance
    logic           iv, ir, en, ov, ordy, err;
    logic [15:0]    a;
    logic [65535:0] dec;
    // small instance: ADDR_W=8, LO_W=3, LIMIT=200
    logic           iv8, ir8, en8, ov8, ordy8, err8;
    logic [7:0]     a8;
    logic [255:0]   dec8;

    int errs = 0;
    int checks = 0;

    selector_pipe dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .addr(a), .en(en),
        .out_valid(ov), .out_ready(ordy), .decoded(dec), .out_err(err)
    );

    selector_pipe #(.ADDR_W(8), .LO_W(3), .LIMIT(200)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .addr(a8), .en(en8),
        .out_valid(ov8), .out_ready(ordy8), .decoded(dec8), .out_err(err8)
    );

    // Reference: the single selected bit, or nothing when deselected / out of range.
    function automatic logic [65535:0] exp16(input logic [15:0] ad, input logic e);
        logic [65535:0] r;
        r = '0;
        if (e) r[ad] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] exp8(input logic [7:0] ad, input logic e);
        logic [255:0] r;
        r = '0;
        if (e && ad <= 8'd200) r[ad] = 1'b1;
        return r;
    endfunction

    function automatic int fb16(input logic [65535:0] v);
        for (int i = 0; i < 65536; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int fb8(input logic [255:0] v);
        for (int i = 0; i < 256; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b1; a = 16'd5; en = 1'b1; ordy = 1'b1;
        iv8 = 1'b0; a8 = '0; en8 = 1'b0; ordy8 = 1'b1;
        repeat (3) begin
            tick(); #1;
            checks++;
            if (ov !== 1'b0 || dec !== '0 || err !== 1'b0 || ir !== 1'b0 || ov8 !== 1'b0) begin
                errs++;
                $display("FAIL reset: ov=%b bit=%0d err=%b ir=%b ov8=%b, want all 0",
                         ov, fb16(dec), err, ir, ov8);
            end
        end
        tick();
        rst = 1'b0; iv = 1'b0;
        #1;
        repeat (4) begin
            checks++;
            if (ov !== 1'b0 || dec !== '0) begin
                errs++;
                $display("FAIL reset_release: ov=%b bit=%0d, want ov=0 no bits", ov, fb16(dec));
            end
            tick(); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ads [4];
        ads[0] = 16'd0; ads[1] = 16'd1; ads[2] = 16'd65535; ads[3] = 16'd32768;
        ordy = 1'b1; en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            iv = (k < 4);
            a = (k < 4) ? ads[k] : 16'd0;
            #1;
            if (k < 4) begin
                checks++;
                if (ir !== 1'b1) begin
                    errs++; $display("FAIL b2b_ready k=%0d: in_ready=%b, want 1", k, ir);
                end
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (ov !== 1'b1 || dec !== exp16(ads[k-2], 1'b1) || err !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_beat k=%0d: ov=%b bit=%0d err=%b, want ov=1 bit=%0d err=0",
                             k, ov, fb16(dec), err, ads[k-2]);
                end
                checks++;
                if ($countones(dec) != 1) begin
                    errs++; $display("FAIL b2b_pop k=%0d: popcount=%0d, want 1", k, $countones(dec));
                end
            end
            if (k == 6) begin
                checks++;
                if (ov !== 1'b0 || dec !== '0) begin
                    errs++; $display("FAIL b2b_bubble: ov=%b bit=%0d, want ov=0 no bits", ov, fb16(dec));
                end
            end
        end
        iv = 1'b0;
    endtask

    task automatic test_limit();
        logic [7:0] ads [3];
        logic       ens [3];
        ads[0] = 8'd200; ens[0] = 1'b1;
        ads[1] = 8'd201; ens[1] = 1'b1;
        ads[2] = 8'd201; ens[2] = 1'b0;
        ordy8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            iv8 = (k < 3);
            a8  = (k < 3) ? ads[k] : 8'd0;
            en8 = (k < 3) ? ens[k] : 1'b0;
            #1;
            if (k >= 2) begin
                checks++;
                if (ov8 !== 1'b1 || dec8 !== exp8(ads[k-2], ens[k-2]) ||
                    err8 !== (ens[k-2] && ads[k-2] > 8'd200)) begin
                    errs++;
                    $display("FAIL limit addr=%0d en=%b: ov=%b bit=%0d err=%b, want ov=1 bit=%0d err=%b",
                             ads[k-2], ens[k-2], ov8, fb8(dec8), err8, fb8(exp8(ads[k-2], ens[k-2])),
                             ens[k-2] && ads[k-2] > 8'd200);
                end
            end
        end
        iv8 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0]    q[$];
        logic [15:0]    exp_a;
        logic [65535:0] prev_dec;
        logic           prev_err;
        logic           prev_stall;
        logic           exp_ir;
        int             nxt, rx, cyc;
        nxt = 10; rx = 0; cyc = 0; prev_stall = 1'b0; prev_dec = '0; prev_err = 1'b0;
        en = 1'b1;
        while (rx < 10 && cyc < 300) begin
            tick();
            ordy = 1'($urandom_range(0, 1));
            iv   = (nxt < 20);
            a    = 16'(nxt);
            #1;
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || dec !== prev_dec || err !== prev_err) begin
                    errs++;
                    $display("FAIL bp_stall: ov=%b bit=%0d, want held bit=%0d", ov, fb16(dec), fb16(prev_dec));
                end
            end
            // Two beats in flight means both stages are occupied.
            exp_ir = !(q.size() == 2 && !ordy);
            checks++;
            if (ir !== exp_ir) begin
                errs++;
                $display("FAIL bp_ready: in_ready=%b, want %b (in flight %0d)", ir, exp_ir, q.size());
            end
            if (ov === 1'b1 && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL bp_extra: beat bit=%0d, want none", fb16(dec));
                end else begin
                    exp_a = q.pop_front();
                    if (dec !== exp16(exp_a, 1'b1) || err !== 1'b0) begin
                        errs++;
                        $display("FAIL bp_order: bit=%0d err=%b, want bit=%0d err=0", fb16(dec), err, exp_a);
                    end
                end
                rx++;
            end
            if (iv && ir === 1'b1) begin
                q.push_back(a);
                nxt++;
            end
            prev_stall = (ov === 1'b1) && !ordy;
            prev_dec   = dec;
            prev_err   = err;
            cyc++;
        end
        checks++;
        if (rx != 10) begin
            errs++; $display("FAIL bp_timeout: received %0d beats, want 10", rx);
        end
        iv = 1'b0; ordy = 1'b1;
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        tick(); ordy = 1'b0; iv = 1'b1; a = 16'd7;
        tick(); a = 16'd8;
        tick(); iv = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (ir !== 1'b0) begin
            errs++; $display("FAIL rmid_ready: in_ready=%b during rst, want 0", ir);
        end
        tick(); rst = 1'b0; iv = 1'b1; a = 16'd9; ordy = 1'b1;
        #1;
        checks++;
        if (ov !== 1'b0 || dec !== '0 || ir !== 1'b1) begin
            errs++;
            $display("FAIL rmid_flush: ov=%b bit=%0d ir=%b, want ov=0 no bits ir=1", ov, fb16(dec), ir);
        end
        tick(); iv = 1'b0;
        #1;
        checks++;
        if (ov !== 1'b0) begin
            errs++; $display("FAIL rmid_early: ov=%b bit=%0d, want ov=0", ov, fb16(dec));
        end
        tick(); #1;
        checks++;
        if (ov !== 1'b1 || dec !== exp16(16'd9, 1'b1)) begin
            errs++; $display("FAIL rmid_beat9: ov=%b bit=%0d, want ov=1 bit=9", ov, fb16(dec));
        end
        tick(); #1;
        checks++;
        if (ov !== 1'b0) begin
            errs++; $display("FAIL rmid_dup: ov=%b bit=%0d, want ov=0", ov, fb16(dec));
        end
    endtask

    task automatic test_random();
        logic [15:0] ads [10];
        logic [15:0] j;
        for (int i = 0; i < 10; i++) ads[i] = 16'($urandom);
        ordy = 1'b1; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            iv = (k < 10);
            a  = (k < 10) ? ads[k] : 16'd0;
            #1;
            if (k >= 2) begin
                j = ads[k-2];
                checks++;
                if (ov !== 1'b1 || dec[j] !== 1'b1 || $countones(dec) != 1) begin
                    errs++;
                    $display("FAIL rand_hit addr=%0d: ov=%b bit=%0d pop=%0d, want ov=1 pop=1",
                             j, ov, fb16(dec), $countones(dec));
                end
                if (j > 0) begin
                    checks++;
                    if (dec[j-1] !== 1'b0) begin
                        errs++; $display("FAIL rand_lo addr=%0d: bit below set, want clear", j);
                    end
                end
                if (j < 16'hFFFF) begin
                    checks++;
                    if (dec[j+1] !== 1'b0) begin
                        errs++; $display("FAIL rand_hi addr=%0d: bit above set, want clear", j);
                    end
                end
            end
        end
        iv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_limit();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
